// File: rtl/i2c_codec_target.sv
// i2c_codec_target: write-only I2C target that collects fixed-length codec
// control frames (address byte + NUM_BYTES-1 data bytes) and presents each
// complete frame as one parallel word.
//
// Ports:
//   clk            system clock (>= 8x SCL)
//   reset          asynchronous active-low reset
//   i2c_sclk       bus clock from the controller
//   i2c_sdat       open-drain data; pulled low by the target only to ACK
//   data_out       last valid frame payload, first data byte in the MSBs
//   data_valid     one-cycle pulse, data_out updated in the same cycle
//   busy           high from START until STOP, abort or timeout
//   frame_err      one-cycle pulse on STOP with a wrong data-byte count
//   timeout_err    one-cycle pulse when the bus stalls while busy
//   frame_cnt      count of valid frames (wraps)
//
// Optional build macro SCL_MEASURE_EN adds:
//   scl_period     clk cycles between consecutive SCL rising edges
//   scl_jitter_err one-cycle pulse when a bit period drifts by more than
//                  one cycle from the previous bit of the same byte

module i2c_codec_target #(
   parameter logic [6:0]  DEV_ADDR    = 7'h1A,
   parameter int unsigned NUM_BYTES   = 3,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i2c_sclk,
   inout  wire                          i2c_sdat,
   output logic [8*(NUM_BYTES-1)-1:0]   data_out,
   output logic                         data_valid,
   output logic                         busy,
   output logic                         frame_err,
   output logic                         timeout_err,
   output logic [15:0]                  frame_cnt
`ifdef SCL_MEASURE_EN
   ,
   output logic [15:0]                  scl_period,
   output logic                         scl_jitter_err
`endif
);

   localparam int unsigned DATA_BYTES = NUM_BYTES - 1;
   localparam int unsigned PAY_W      = 8 * DATA_BYTES;
   localparam int unsigned BCW        = $clog2(NUM_BYTES + 1);
   localparam int unsigned TOW        = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      IDLE, ADDR, ACK_A, DATA, ACK_D, IGNORE
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_prev_q, sda_prev_q;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic                   ack_ph_q, ack_ph_d;
   logic                   addr_ok_q, addr_ok_d;
   logic                   sda_oe_q, sda_oe_d;
   logic [PAY_W-1:0]       payload_q, payload_d;
   logic [TOW-1:0]         to_cnt_q, to_cnt_d;
   logic [PAY_W-1:0]       data_out_q, data_out_d;
   logic                   data_valid_q, data_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   timeout_err_q, timeout_err_d;
   logic [15:0]            frame_cnt_q, frame_cnt_d;
   logic                   busy_q, busy_d;

   logic scl_s_c, sda_s_c, scl_rise_c, scl_fall_c, start_c, stop_c;
   logic match_c, to_hit_c, room_c;
   int unsigned sh_c;

   // Open-drain driver: only ever pull low.
   assign i2c_sdat = sda_oe_q ? 1'b0 : 1'bz;

   // Bus conditions seen on the synchronised samples.
   assign scl_s_c    = scl_sync_q[SYNC_STAGES-1];
   assign sda_s_c    = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise_c = scl_s_c & ~scl_prev_q;
   assign scl_fall_c = ~scl_s_c & scl_prev_q;
   assign start_c    = scl_s_c & scl_prev_q & sda_prev_q & ~sda_s_c;
   assign stop_c     = scl_s_c & scl_prev_q & ~sda_prev_q & sda_s_c;
   assign match_c    = (shift_q[7:1] == DEV_ADDR) && !shift_q[0];
   assign room_c     = byte_cnt_q < BCW'(DATA_BYTES);
   assign to_hit_c   = (state_q != IDLE) && !scl_rise_c && !scl_fall_c &&
                       (to_cnt_q == TOW'(TIMEOUT_CYC - 1));

   // Next-state and output logic.
   always_comb begin
      state_d       = state_q;
      scl_sync_d    = {scl_sync_q[SYNC_STAGES-2:0], i2c_sclk};
      sda_sync_d    = {sda_sync_q[SYNC_STAGES-2:0], i2c_sdat};
      bit_cnt_d     = bit_cnt_q;
      byte_cnt_d    = byte_cnt_q;
      shift_d       = shift_q;
      ack_ph_d      = ack_ph_q;
      addr_ok_d     = addr_ok_q;
      sda_oe_d      = sda_oe_q;
      payload_d     = payload_q;
      data_out_d    = data_out_q;
      data_valid_d  = 1'b0;
      frame_err_d   = 1'b0;
      timeout_err_d = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      sh_c          = 0;
      to_cnt_d      = (state_q == IDLE || scl_rise_c || scl_fall_c) ?
                      '0 : TOW'(to_cnt_q + TOW'(1));

      if (start_c) begin
         // START or repeated START: any partial frame is dropped silently.
         state_d    = ADDR;
         bit_cnt_d  = '0;
         byte_cnt_d = '0;
         ack_ph_d   = 1'b0;
         addr_ok_d  = 1'b0;
         sda_oe_d   = 1'b0;
      end else if (stop_c && state_q != IDLE) begin
         state_d  = IDLE;
         sda_oe_d = 1'b0;
         ack_ph_d = 1'b0;
         if (addr_ok_q) begin
            if (byte_cnt_q == BCW'(DATA_BYTES)) begin
               data_valid_d = 1'b1;
               data_out_d   = payload_q;
               frame_cnt_d  = 16'(frame_cnt_q + 16'd1);
            end else begin
               frame_err_d = 1'b1;
            end
         end
      end else if (to_hit_c) begin
         state_d       = IDLE;
         sda_oe_d      = 1'b0;
         ack_ph_d      = 1'b0;
         timeout_err_d = 1'b1;
      end else begin
         case (state_q)
            ADDR, DATA: begin
               if (scl_rise_c) begin
                  shift_d   = {shift_q[6:0], sda_s_c};
                  bit_cnt_d = 3'(bit_cnt_q + 3'd1);
                  if (bit_cnt_q == 3'd7) begin
                     state_d = (state_q == ADDR) ? ACK_A : ACK_D;
                     // Store the completed data byte; an excess byte is dropped.
                     if (state_q == DATA && room_c) begin
                        sh_c      = 8 * (DATA_BYTES - 1 - 32'(byte_cnt_q));
                        payload_d = (payload_q & ~(PAY_W'(8'hFF) << sh_c)) |
                                    (PAY_W'(shift_d) << sh_c);
                     end
                  end
               end
            end
            // First SCL fall after the 8th bit drives the ACK, the next releases it.
            ACK_A: begin
               if (scl_fall_c) begin
                  if (!ack_ph_q) begin
                     ack_ph_d  = 1'b1;
                     sda_oe_d  = match_c;
                     addr_ok_d = match_c;
                  end else begin
                     ack_ph_d = 1'b0;
                     sda_oe_d = 1'b0;
                     state_d  = addr_ok_q ? DATA : IGNORE;
                  end
               end
            end
            ACK_D: begin
               if (scl_fall_c) begin
                  if (!ack_ph_q) begin
                     ack_ph_d = 1'b1;
                     sda_oe_d = room_c;
                  end else begin
                     ack_ph_d   = 1'b0;
                     sda_oe_d   = 1'b0;
                     byte_cnt_d = BCW'(byte_cnt_q + BCW'(1));
                     state_d    = room_c ? DATA : IGNORE;
                  end
               end
            end
            default: ;
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         scl_sync_q    <= '1;
         sda_sync_q    <= '1;
         scl_prev_q    <= 1'b1;
         sda_prev_q    <= 1'b1;
         bit_cnt_q     <= '0;
         byte_cnt_q    <= '0;
         shift_q       <= '0;
         ack_ph_q      <= 1'b0;
         addr_ok_q     <= 1'b0;
         sda_oe_q      <= 1'b0;
         payload_q     <= '0;
         to_cnt_q      <= '0;
         data_out_q    <= '0;
         data_valid_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         timeout_err_q <= 1'b0;
         frame_cnt_q   <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         scl_sync_q    <= scl_sync_d;
         sda_sync_q    <= sda_sync_d;
         scl_prev_q    <= scl_s_c;
         sda_prev_q    <= sda_s_c;
         bit_cnt_q     <= bit_cnt_d;
         byte_cnt_q    <= byte_cnt_d;
         shift_q       <= shift_d;
         ack_ph_q      <= ack_ph_d;
         addr_ok_q     <= addr_ok_d;
         sda_oe_q      <= sda_oe_d;
         payload_q     <= payload_d;
         to_cnt_q      <= to_cnt_d;
         data_out_q    <= data_out_d;
         data_valid_q  <= data_valid_d;
         frame_err_q   <= frame_err_d;
         timeout_err_q <= timeout_err_d;
         frame_cnt_q   <= frame_cnt_d;
         busy_q        <= busy_d;
      end
   end

   assign data_out    = data_out_q;
   assign data_valid  = data_valid_q;
   assign busy        = busy_q;
   assign frame_err   = frame_err_q;
   assign timeout_err = timeout_err_q;
   assign frame_cnt   = frame_cnt_q;

`ifdef SCL_MEASURE_EN
   logic [15:0] per_cnt_q, per_cnt_d;
   logic [15:0] scl_period_q, scl_period_d;
   logic        jitter_q, jitter_d;
   logic [15:0] per_diff_c;

   // Period counter; bit k (k >= 2) of a byte is compared with bit k-1, so
   // neither the ACK bit nor the first bit after it takes part.
   always_comb begin
      per_cnt_d    = scl_rise_c ? 16'd1 :
                     (per_cnt_q == 16'hFFFF) ? per_cnt_q : 16'(per_cnt_q + 16'd1);
      scl_period_d = scl_period_q;
      jitter_d     = 1'b0;
      per_diff_c   = (per_cnt_q > scl_period_q) ? 16'(per_cnt_q - scl_period_q) :
                                                  16'(scl_period_q - per_cnt_q);
      if (scl_rise_c && state_q != IDLE) begin
         scl_period_d = per_cnt_q;
         if ((state_q == ADDR || state_q == DATA) && bit_cnt_q >= 3'd2)
            jitter_d = (per_diff_c > 16'd1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         per_cnt_q    <= '0;
         scl_period_q <= '0;
         jitter_q     <= 1'b0;
      end else begin
         per_cnt_q    <= per_cnt_d;
         scl_period_q <= scl_period_d;
         jitter_q     <= jitter_d;
      end
   end

   assign scl_period     = scl_period_q;
   assign scl_jitter_err = jitter_q;
`endif

endmodule

// File: tb/tb_i2c_codec_target.sv
// Directed + randomized bench for i2c_codec_target (DEV_ADDR 7'h1A, 3 bytes).
// A simple controller model drives SCL/SDA; expected ACKs and frame outcomes
// come from the frame-level rules (address match, data-byte count).

module tb_i2c_codec_target;

   localparam logic [6:0] DEV = 7'h1A;
   localparam int         NB  = 3;
   localparam int         PW  = 8 * (NB - 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          scl = 1'b1;
   logic          tb_low = 1'b0;
   wire           sda;
   logic [PW-1:0] data_out;
   logic          data_valid, busy, frame_err, timeout_err;
   logic [15:0]   frame_cnt;
`ifdef SCL_MEASURE_EN
   logic [15:0]   scl_period;
   logic          scl_jitter_err;
`endif

   assign sda = tb_low ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_codec_target #(.DEV_ADDR(DEV), .NUM_BYTES(NB), .SYNC_STAGES(2), .TIMEOUT_CYC(4096)) dut (
      .clk        (clk),
      .reset      (rst_n),
      .i2c_sclk   (scl),
      .i2c_sdat   (sda),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy),
      .frame_err  (frame_err),
      .timeout_err(timeout_err),
      .frame_cnt  (frame_cnt)
`ifdef SCL_MEASURE_EN
      ,
      .scl_period    (scl_period),
      .scl_jitter_err(scl_jitter_err)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, nvalid = 0, nferr = 0, nto = 0, to_cyc = 0, viol = 0, njit = 0;
   int last_fall = 0;
   int q = 6;
   int stretch_at = -1;
   logic scl_prev = 1'b1, dl_prev = 1'b0;
   wire  dut_low = (sda === 1'b0) && !tb_low;

   // Event monitor: pulse counts and SDA movement by the target while SCL high.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (data_valid === 1'b1) nvalid <= nvalid + 1;
      if (frame_err === 1'b1) nferr <= nferr + 1;
      if (timeout_err === 1'b1) begin
         nto <= nto + 1;
         to_cyc <= cyc;
      end
`ifdef SCL_MEASURE_EN
      if (scl_jitter_err === 1'b1) njit <= njit + 1;
`endif
      if (rst_n && scl && scl_prev && (dut_low != dl_prev)) viol <= viol + 1;
      scl_prev <= scl;
      dl_prev  <= dut_low;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic i2c_start();
      tb_low = 1'b0; scl = 1'b1; tick(q);
      tb_low = 1'b1; tick(q);
      scl = 1'b0; tick(q);
   endtask

   task automatic i2c_rstart();
      tb_low = 1'b0; tick(q);
      scl = 1'b1; tick(q);
      tb_low = 1'b1; tick(q);
      scl = 1'b0; tick(q);
   endtask

   task automatic i2c_stop();
      tb_low = 1'b1; tick(q);
      scl = 1'b1; tick(q);
      tb_low = 1'b0; tick(2 * q);
   endtask

   task automatic i2c_bit(input logic b, input int idx);
      tb_low = !b;
      if (idx == stretch_at) tick(20);
      tick(q);
      scl = 1'b1; tick(2 * q);
      scl = 1'b0; tick(q);
   endtask

   // One byte plus the ACK clock; the ACK is sampled mid SCL-high.
   task automatic i2c_byte(input logic [7:0] b, input logic exp_ack, input string tag);
      logic got;
      for (int i = 7; i >= 0; i--) i2c_bit(b[i], 7 - i);
      tb_low = 1'b0; tick(q);
      scl = 1'b1; tick(q);
      got = (sda === 1'b0);
      tick(q);
      scl = 1'b0;
      last_fall = cyc;
      tick(q);
      check({tag, "_ack"}, 32'(got), 32'(exp_ack));
   endtask

   // Reference rules: ACK the address when it matches a write, then at most
   // NB-1 data bytes.
   function automatic logic exp_ack_f(input logic [7:0] a, input int idx);
      return (a[7:1] == DEV) && (a[0] == 1'b0) && (idx <= NB - 1);
   endfunction

   logic [7:0]    fq[$];
   logic [PW-1:0] mdl_data = '0;
   logic [15:0]   mdl_cnt = '0;

   task automatic send_frame(input string tag);
      int v0, f0, ev, ef;
      logic m;
      v0 = nvalid; f0 = nferr; ev = 0; ef = 0;
      m = exp_ack_f(fq[0], 0);
      i2c_start();
      check({tag, "_busy"}, 32'(busy), 32'd1);
      for (int i = 0; i < fq.size(); i++)
         i2c_byte(fq[i], exp_ack_f(fq[0], i), $sformatf("%s_b%0d", tag, i));
      i2c_stop();
      tick(6);
      if (m && (fq.size() - 1 == NB - 1)) begin
         ev = 1;
         mdl_data = '0;
         for (int i = 1; i < fq.size(); i++) mdl_data = (mdl_data << 8) | PW'(fq[i]);
         mdl_cnt = mdl_cnt + 16'd1;
      end else if (m) begin
         ef = 1;
      end
      check({tag, "_valid"}, 32'(nvalid - v0), 32'(ev));
      check({tag, "_ferr"}, 32'(nferr - f0), 32'(ef));
      check({tag, "_data"}, 32'(data_out), 32'(mdl_data));
      check({tag, "_cnt"}, 32'(frame_cnt), 32'(mdl_cnt));
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   int v0, f0, t0, j0;
   logic [7:0] a;

   initial begin
      tick(4);
      rst_n = 1'b1;
      tick(4);
      check("rst_data", 32'(data_out), 32'd0);
      check("rst_valid", 32'(data_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ferr", 32'(frame_err), 32'd0);
      check("rst_tout", 32'(timeout_err), 32'd0);
      check("rst_cnt", 32'(frame_cnt), 32'd0);
      check("rst_sda", 32'(sda === 1'b1), 32'd1);

      fq = '{8'h34, 8'h1E, 8'h00};          send_frame("good");
      fq = '{8'h36, 8'h12};                 send_frame("nack");
      fq = '{8'h34, 8'h0C};                 send_frame("short");
      fq = '{8'h34, 8'h0C, 8'h9F, 8'hAA};   send_frame("long");
      fq = '{8'h35, 8'h01, 8'h02};          send_frame("read");

      // Repeated START discards the partial frame without an error.
      v0 = nvalid; f0 = nferr;
      i2c_start();
      i2c_byte(8'h34, 1'b1, "rs_a0");
      i2c_byte(8'h11, 1'b1, "rs_d0");
      i2c_rstart();
      i2c_byte(8'h34, 1'b1, "rs_a1");
      i2c_byte(8'hAB, 1'b1, "rs_d1");
      i2c_byte(8'hCD, 1'b1, "rs_d2");
      i2c_stop();
      tick(6);
      mdl_data = 16'hABCD; mdl_cnt = mdl_cnt + 16'd1;
      check("rs_valid", 32'(nvalid - v0), 32'd1);
      check("rs_ferr", 32'(nferr - f0), 32'd0);
      check("rs_data", 32'(data_out), 32'(mdl_data));
      check("rs_cnt", 32'(frame_cnt), 32'(mdl_cnt));

      // Bus stall while busy.
      v0 = nvalid; f0 = nferr; t0 = nto;
      i2c_start();
      i2c_byte(8'h34, 1'b1, "to_a");
      tick(5000);
      check("to_pulse", 32'(nto - t0), 32'd1);
      check("to_when", 32'((to_cyc - last_fall) >= 4090 && (to_cyc - last_fall) <= 4110), 32'd1);
      check("to_busy", 32'(busy), 32'd0);
      check("to_sda", 32'(sda === 1'b1), 32'd1);
      check("to_ferr", 32'(nferr - f0), 32'd0);
      check("to_valid", 32'(nvalid - v0), 32'd0);
      i2c_stop();
      tick(4);

      for (int it = 0; it < 14; it++) begin
         int r, n;
         r = $urandom_range(0, 9);
         a = (r == 6) ? 8'h35 : (r == 7) ? 8'($urandom) : 8'h34;
         n = $urandom_range(0, 4);
         fq.delete();
         fq.push_back(a);
         for (int k = 0; k < n; k++) fq.push_back(8'($urandom));
         send_frame($sformatf("rnd%0d", it));
      end

`ifdef SCL_MEASURE_EN
      q = 125;
      j0 = njit;
      fq = '{8'h34, 8'h1E, 8'h00}; send_frame("meas");
      check("meas_period", 32'(scl_period), 32'd500);
      check("meas_nojit", 32'(njit - j0), 32'd0);
      stretch_at = 3;
      fq = '{8'h34}; send_frame("jit");
      check("jit_pulse", 32'(njit > j0), 32'd1);
      stretch_at = -1;
      q = 6;
`endif

      // Reset while the target holds a data-byte ACK.
      i2c_start();
      i2c_byte(8'h34, 1'b1, "ra_a");
      for (int i = 7; i >= 0; i--) i2c_bit(1'b0, 7 - i);
      tb_low = 1'b0;
      tick(1);
      check("ra_drive", 32'(sda === 1'b0), 32'd1);
      rst_n = 1'b0;
      #1;
      check("ra_release", 32'(sda === 1'b1), 32'd1);
      tick(3);
      rst_n = 1'b1;
      mdl_data = '0; mdl_cnt = '0;
      tick(2);
      check("ra_busy", 32'(busy), 32'd0);
      check("ra_cnt", 32'(frame_cnt), 32'd0);
      check("ra_data", 32'(data_out), 32'd0);
      i2c_stop();
      tick(4);

      fq = '{8'h34, 8'h0E, 8'h42}; send_frame("post");
      check("post_word", 32'(data_out), 32'h0E42);

      check("sda_stable", 32'(viol), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_codec_target.md
Name: i2c_codec_target

Overview:
- Synthesizable, parametrised I2C target (write-only) that receives codec control frames of NUM_BYTES bytes: address byte plus (NUM_BYTES-1) data bytes.
- Oversamples i2c_sclk/i2c_sdat on clk, detects START/STOP, checks the device address and generates ACK/NACK on the open-drain bus.
- Presents each completed frame as one parallel word with a valid pulse.
- Sits in the codec-side model/FPGA loopback, replacing fixed-format behavioural listeners so controller RTL can be checked against arbitrary frame lengths and addresses.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit device address to match.
- NUM_BYTES, 3, bytes per frame including address byte; range 2..8.
- SYNC_STAGES, 2, synchroniser depth on SCL and SDA; minimum 2.
- TIMEOUT_CYC, 4096, clk cycles without an SCL edge while busy before abort.

Ports:
- clk  in  1  system clock; at least 8x SCL frequency.
- reset  in  1  asynchronous, active-low reset.
- i2c_sclk  in  1  bus clock from the controller.
- i2c_sdat  inout  1  open-drain data; driven 1'b0 when sda_oe=1, else 1'bz.
- data_out  out  8*(NUM_BYTES-1)  last valid frame payload; first data byte in the MSBs.
- data_valid  out  1  one-cycle pulse; data_out is updated in the same cycle.
- busy  out  1  high from START until STOP, abort or timeout.
- frame_err  out  1  one-cycle pulse on a STOP with a wrong data-byte count.
- timeout_err  out  1  one-cycle pulse on timeout abort.
- frame_cnt  out  16  count of valid frames; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset:
  - All outputs 0; sda_oe = 0 (bus released); state = IDLE.
  - Synchroniser flops reset to 1 (idle-high bus).
  - Reset asserted mid-frame releases SDA immediately.
- Edge detection:
  - Uses synchronised signals; edge = change versus the previous sample.
  - START: SDA 1->0 while SCL = 1.
  - STOP: SDA 0->1 while SCL = 1.
- FSM states: IDLE, ADDR, ACK_A, DATA, ACK_D, IGNORE.
- IDLE:
  - START -> ADDR; bit counter = 0, byte counter = 0, busy = 1.
  - Any other activity is ignored.
- ADDR:
  - Shift SDA in on each SCL rising edge, MSB first.
  - After 8 bits -> ACK_A.
- ACK_A:
  - On the next SCL falling edge, sda_oe = 1 only if addr[7:1] == DEV_ADDR and addr[0] == 0 (write).
  - On a mismatch or a read, SDA stays released (NACK).
  - On the following SCL falling edge, release SDA.
  - Next state is DATA on a match, otherwise IGNORE.
- DATA:
  - Shift 8 bits into the payload register at byte index byte_cnt, then -> ACK_D.
- ACK_D:
  - ACK using the same two-falling-edge timing as ACK_A; byte_cnt increments.
  - If byte_cnt was already NUM_BYTES-1, the excess byte is NACKed -> IGNORE.
  - Otherwise -> DATA.
- IGNORE: wait for STOP or START; never drives SDA.
- STOP in any non-IDLE state:
  - -> IDLE, busy = 0, SDA released.
  - If the address matched and byte_cnt == NUM_BYTES-1: pulse data_valid, latch data_out, increment frame_cnt.
  - Else, if the address matched: pulse frame_err (short or long frame).
  - An address NACK followed by STOP is not an error.
- Repeated START in any state:
  - Restart at ADDR; the partial frame is discarded without frame_err.
- Timeout: busy and no SCL edge for TIMEOUT_CYC cycles -> IDLE, release SDA, pulse timeout_err.
- Latency: data_valid is asserted SYNC_STAGES+1 clk cycles after the STOP condition on the pins.
- SDA changes only while SCL is low, except when releasing on STOP or reset.

Optional Feature:
- Macro SCL_MEASURE_EN.
- When defined:
  - Adds outputs scl_period[15:0] (clk cycles between consecutive SCL rising edges, latched every edge while busy) and scl_jitter_err (one-cycle pulse).
  - scl_jitter_err fires when a period differs from the previous one within the same byte by more than 1 cycle.
  - The ACK-bit period is excluded from the jitter check (clock stretching is not supported).
- When undefined:
  - Ports absent, no counter logic.
  - Timeout uses its own counter in both builds.

Test Plan:
- DEV_ADDR=7'h1A, NUM_BYTES=3:
  - Send START, 0x34, 0x1E, 0x00, STOP -> three ACKs (SDA low at ACK SCL-high).
  - data_valid pulses once, data_out = 16'h1E00, frame_cnt = 1.
- Send START, 0x36, 0x12, STOP -> address NACK, SDA never driven, no data_valid, no frame_err, frame_cnt unchanged.
- Send START, 0x34, 0x0C, STOP (short frame) -> frame_err pulse, data_out holds previous value.
- Send START, 0x34, 0x0C, 0x9F, 0xAA, STOP -> 4th byte NACKed, frame_err pulse, no data_valid.
- Send START, 0x34, then hold SCL low for 5000 clk -> timeout_err pulse at cycle 4096, busy = 0, SDA released.
- Assert reset during a data-byte ACK -> SDA released within 1 cycle.
- Next frame START, 0x34, 0x0E, 0x42, STOP -> data_out = 16'h0E42.
- With SCL_MEASURE_EN, 100 kHz SCL on 50 MHz clk -> scl_period = 500.
- Stretching one bit period to 520 -> scl_jitter_err pulse.
